// File: rtl/fir_pkg.sv
// Shared state type and phase constants for the FIR frame sequencer.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SHIFT,
    MAC,
    SUM,
    WAIT,
    UPD
  } fir_state_e;

  localparam int unsigned FIR_CLK_DIV      = 20;
  localparam int unsigned FIR_TAPS_PER_MAC = 10;
  localparam int unsigned FIR_ADDR_W       = 4;

  localparam int unsigned C_CLR = 2;
  localparam int unsigned C_SUM = FIR_TAPS_PER_MAC + 3;

  // Phase of the Sum-stage enable for an arbitrary tap count.
  function automatic int unsigned c_sum(input int unsigned taps);
    return taps + 3;
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Control/handshake bundle between the FIR sequencer, the host and the MAC datapath.
// FIR_SEQ_SKIP_CNT_EN adds the oSkipCnt observation counter.
interface fir_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);

  logic              iEnable;
  logic              iCoefUpdReq;
  logic              iCoefUpdDone;
  logic              oCoefUpdGnt;
  logic              oEnSample600k;
  logic              oEnDelay;
  logic              oMacClr;
  logic              oCoefRdEn;
  logic [ADDR_W-1:0] oCoefAddr;
  logic              oMacEn;
  logic              oSumEn;
  logic              oBusy;
`ifdef FIR_SEQ_SKIP_CNT_EN
  logic [15:0]       oSkipCnt;

  modport master (
    input  iEnable, iCoefUpdReq, iCoefUpdDone,
    output oCoefUpdGnt, oEnSample600k, oEnDelay, oMacClr, oCoefRdEn,
           oCoefAddr, oMacEn, oSumEn, oBusy, oSkipCnt
  );

  modport slave (
    output iEnable, iCoefUpdReq, iCoefUpdDone,
    input  oCoefUpdGnt, oEnSample600k, oEnDelay, oMacClr, oCoefRdEn,
           oCoefAddr, oMacEn, oSumEn, oBusy, oSkipCnt
  );
`else
  modport master (
    input  iEnable, iCoefUpdReq, iCoefUpdDone,
    output oCoefUpdGnt, oEnSample600k, oEnDelay, oMacClr, oCoefRdEn,
           oCoefAddr, oMacEn, oSumEn, oBusy
  );

  modport slave (
    output iEnable, iCoefUpdReq, iCoefUpdDone,
    input  oCoefUpdGnt, oEnSample600k, oEnDelay, oMacClr, oCoefRdEn,
           oCoefAddr, oMacEn, oSumEn, oBusy
  );
`endif

endinterface

// File: rtl/fir_frame_cnt.sv
// Modulo-CLK_DIV frame phase counter with synchronous clear and a wrap flag.
// Also exposes the next count so the sequencer can register phase-aligned outputs.
module fir_frame_cnt #(
  parameter int unsigned CLK_DIV = 20,
  parameter int unsigned CW      = $clog2(CLK_DIV)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_nxt_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign wrap_o    = (cnt_q == LAST);

endmodule

// File: rtl/fir_seq_ctrl.sv
// Frame sequencer for the 4-MAC FIR datapath plus host coefficient-RAM arbitration.
// FIR_SEQ_SKIP_CNT_EN adds a saturating count of frames strobed while the host owns the RAMs.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned CLK_DIV      = FIR_CLK_DIV,
  parameter int unsigned TAPS_PER_MAC = FIR_TAPS_PER_MAC,
  parameter int unsigned ADDR_W       = FIR_ADDR_W
) (
  input  logic           iClk12M,
  input  logic           iRsn,
  fir_seq_ctrl_if.master bus
);

  localparam int unsigned   CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CLR_C     = CW'(C_CLR);
  localparam logic [CW-1:0] RD_LAST   = CW'(TAPS_PER_MAC + 1);
  localparam logic [CW-1:0] MAC_FIRST = CW'(C_CLR + 1);
  localparam logic [CW-1:0] MAC_LAST  = CW'(c_sum(TAPS_PER_MAC) - 1);

  fir_state_e        state_q, state_d;
  logic [CW-1:0]     c_q, c_d;
  logic              wrap;
  logic              cnt_clr;

  logic              sample_q, sample_d;
  logic              delay_q, delay_d;
  logic              clr_q, clr_d;
  logic              rden_q, rden_d;
  logic              macen_q, macen_d;
  logic              sumen_q, sumen_d;
  logic              busy_q, busy_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Counter sits at 0 throughout IDLE and is zeroed on every entry to or exit from it.
  assign cnt_clr = (state_q == IDLE) || (state_d == IDLE);

  fir_frame_cnt #(
    .CLK_DIV (CLK_DIV),
    .CW      (CW)
  ) u_frame_cnt (
    .clk_i     (iClk12M),
    .rst_ni    (iRsn),
    .clr_i     (cnt_clr),
    .cnt_o     (c_q),
    .cnt_nxt_o (c_d),
    .wrap_o    (wrap)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.iCoefUpdReq)  state_d = UPD;
        else if (bus.iEnable) state_d = SAMPLE;
      end
      SAMPLE: state_d = SHIFT;
      SHIFT:  state_d = MAC;
      MAC:    if (c_q == MAC_LAST) state_d = SUM;
      SUM:    state_d = WAIT;
      WAIT: begin
        if (wrap) begin
          if (bus.iCoefUpdReq)  state_d = UPD;
          else if (bus.iEnable) state_d = SAMPLE;
          else                  state_d = IDLE;
        end
      end
      UPD:     if (bus.iCoefUpdDone) state_d = bus.iEnable ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state/phase so the registered strobes line up with c.
  always_comb begin
    sample_d = 1'b0;
    delay_d  = 1'b0;
    clr_d    = 1'b0;
    rden_d   = 1'b0;
    macen_d  = 1'b0;
    sumen_d  = 1'b0;
    busy_d   = 1'b0;
    gnt_d    = 1'b0;
    addr_d   = addr_q;
    case (state_d)
      SAMPLE: begin
        sample_d = 1'b1;
        busy_d   = 1'b1;
      end
      SHIFT: begin
        delay_d = 1'b1;
        busy_d  = 1'b1;
      end
      MAC: begin
        busy_d  = 1'b1;
        clr_d   = (c_d == CLR_C);
        rden_d  = (c_d <= RD_LAST);
        macen_d = (c_d >= MAC_FIRST);
        if (rden_d) addr_d = ADDR_W'(c_d - CLR_C);
      end
      SUM: begin
        sumen_d = 1'b1;
        busy_d  = 1'b1;
      end
      UPD: begin
        gnt_d    = 1'b1;
        sample_d = (c_d == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q  <= IDLE;
      sample_q <= 1'b0;
      delay_q  <= 1'b0;
      clr_q    <= 1'b0;
      rden_q   <= 1'b0;
      macen_q  <= 1'b0;
      sumen_q  <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      delay_q  <= delay_d;
      clr_q    <= clr_d;
      rden_q   <= rden_d;
      macen_q  <= macen_d;
      sumen_q  <= sumen_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
    end
  end

  assign bus.oEnSample600k = sample_q;
  assign bus.oEnDelay      = delay_q;
  assign bus.oMacClr       = clr_q;
  assign bus.oCoefRdEn     = rden_q;
  assign bus.oCoefAddr     = addr_q;
  assign bus.oMacEn        = macen_q;
  assign bus.oSumEn        = sumen_q;
  assign bus.oBusy         = busy_q;
  assign bus.oCoefUpdGnt   = gnt_q;

`ifdef FIR_SEQ_SKIP_CNT_EN
  logic [15:0] skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    if (gnt_d && sample_d && (skip_q != '1)) skip_d = skip_q + 16'd1;
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) skip_q <= '0;
    else       skip_q <= skip_d;
  end

  assign bus.oSkipCnt = skip_q;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: frame-level reference model plus directed and random host traffic.
module tb_fir_seq_ctrl;

  localparam int D  = 20;
  localparam int T  = 10;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fir_seq_ctrl_if #(.ADDR_W(AW)) bus ();

  fir_seq_ctrl #(
    .CLK_DIV      (D),
    .TAPS_PER_MAC (T),
    .ADDR_W       (AW)
  ) dut (
    .iClk12M (clk),
    .iRsn    (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT at t=%0t", name, $time);
  endtask

  // Reference model: a frame is either computing, a host-owned (UPD) frame, a quiet hold frame, or idle.
  typedef enum int {M_IDLE, M_FRAME, M_UPD, M_HOLD} mmode_e;
  mmode_e m_mode = M_IDLE;
  int     m_c    = 0;
  int     m_addr = 0;
  int     m_skip = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_c    = 0;
      m_addr = 0;
      m_skip = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_c = 0;
          if (bus.iCoefUpdReq)  m_mode = M_UPD;
          else if (bus.iEnable) m_mode = M_FRAME;
        end
        M_FRAME, M_HOLD: begin
          if (m_c == D - 1) begin
            m_c = 0;
            if (bus.iCoefUpdReq)  m_mode = M_UPD;
            else if (bus.iEnable) m_mode = M_FRAME;
            else                  m_mode = M_IDLE;
          end else m_c = m_c + 1;
        end
        M_UPD: begin
          if (bus.iCoefUpdDone && !bus.iEnable) begin
            m_mode = M_IDLE;
            m_c    = 0;
          end else begin
            if (bus.iCoefUpdDone) m_mode = M_HOLD;
            m_c = (m_c + 1) % D;
          end
        end
        default: m_mode = M_IDLE;
      endcase
      if (m_mode == M_FRAME && m_c >= 2 && m_c <= T + 1) m_addr = m_c - 2;
      if (m_mode == M_UPD && m_c == 0 && m_skip < 65535) m_skip = m_skip + 1;
    end
  end

  always @(negedge clk) begin
    bit fr, up;
    fr = (m_mode == M_FRAME);
    up = (m_mode == M_UPD);
    chk("sample",  int'(bus.oEnSample600k), int'((fr || up) && m_c == 0));
    chk("delay",   int'(bus.oEnDelay),      int'(fr && m_c == 1));
    chk("mac_clr", int'(bus.oMacClr),       int'(fr && m_c == 2));
    chk("rd_en",   int'(bus.oCoefRdEn),     int'(fr && m_c >= 2 && m_c <= T + 1));
    chk("addr",    int'(bus.oCoefAddr),     m_addr);
    chk("mac_en",  int'(bus.oMacEn),        int'(fr && m_c >= 3 && m_c <= T + 2));
    chk("sum_en",  int'(bus.oSumEn),        int'(fr && m_c == T + 3));
    chk("busy",    int'(bus.oBusy),         int'(fr && m_c <= T + 3));
    chk("gnt",     int'(bus.oCoefUpdGnt),   int'(up));
    chk("gnt_busy_excl", int'(bus.oCoefUpdGnt && bus.oBusy), 0);
`ifdef FIR_SEQ_SKIP_CNT_EN
    chk("skip_cnt", int'(bus.oSkipCnt), m_skip);
`endif
  end

  task automatic wait_c(input int c, input string name);
    int n = 0;
    while (!(m_mode == M_FRAME && m_c == c) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout_fail(name);
  endtask

  task automatic pulse_done();
    bus.iCoefUpdDone = 1'b1;
    @(negedge clk);
    bus.iCoefUpdDone = 1'b0;
  endtask

  // Literal per-frame shape, independent of the model.
  task automatic frame_check(input string tag);
    int n = 0;
    int nmac = 0, first_mac = -1, sum_at = -1, del_at = -1, clr_at = -1, addr_bad = 0, nrd = 0;
    while (!bus.oEnSample600k && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      timeout_fail({tag, "_sample"});
      return;
    end
    for (int k = 1; k < D; k++) begin
      @(negedge clk);
      if (bus.oMacEn) begin
        nmac++;
        if (first_mac < 0) first_mac = k;
      end
      if (bus.oSumEn)   sum_at = k;
      if (bus.oEnDelay) del_at = k;
      if (bus.oMacClr)  clr_at = k;
      if (bus.oCoefRdEn) begin
        nrd++;
        if (int'(bus.oCoefAddr) != k - 2) addr_bad++;
      end
    end
    chk({tag, "_nmac"},      nmac, 10);
    chk({tag, "_first_mac"}, first_mac, 3);
    chk({tag, "_sum_at"},    sum_at, 13);
    chk({tag, "_delay_at"},  del_at, 1);
    chk({tag, "_clr_at"},    clr_at, 2);
    chk({tag, "_nrd"},       nrd, 10);
    chk({tag, "_addr_seq"},  addr_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, ns, nm, nsum;
    bus.iEnable      = 1'b0;
    bus.iCoefUpdReq  = 1'b0;
    bus.iCoefUpdDone = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample", int'(bus.oEnSample600k), 0);
    chk("rst_gnt",    int'(bus.oCoefUpdGnt), 0);
    chk("rst_addr",   int'(bus.oCoefAddr), 0);
    chk("rst_busy",   int'(bus.oBusy), 0);

    bus.iEnable = 1'b1;
    rst_n       = 1'b1;
    @(negedge clk);
    chk("first_sample", int'(bus.oEnSample600k), 1);
    frame_check("f1");
    frame_check("f2");

    // Mid-frame update request: grant only after the wrap.
    wait_c(5, "wait_c5");
    bus.iCoefUpdReq = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.oCoefUpdGnt && n < 60);
    chk("gnt_latency", n, 15);
    bus.iCoefUpdReq = 1'b0;
    ns = 0;
    nm = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.oEnSample600k) ns++;
      if (bus.oMacEn) nm++;
    end
    chk("upd_samples", ns, 2);
    chk("upd_no_mac", nm, 0);
    pulse_done();
    chk("gnt_drop", int'(bus.oCoefUpdGnt), 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.oEnSample600k && n < 60);
    chk("resume_latency", n, 9);
    frame_check("resume");

    // Enable dropped mid-frame: the frame still finishes, then idle.
    wait_c(8, "wait_c8");
    bus.iEnable = 1'b0;
    ns = 0;
    nsum = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.oEnSample600k) ns++;
      if (bus.oSumEn) nsum++;
    end
    chk("stop_sums", nsum, 1);
    chk("stop_samples", ns, 0);

    // Request and enable together from idle: update wins.
    bus.iCoefUpdReq = 1'b1;
    bus.iEnable     = 1'b1;
    @(negedge clk);
    chk("idle_upd_gnt", int'(bus.oCoefUpdGnt), 1);
    chk("idle_upd_sample", int'(bus.oEnSample600k), 1);
    bus.iCoefUpdReq = 1'b0;
    nm = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.oMacEn) nm++;
    end
    chk("idle_upd_no_mac", nm, 0);
    pulse_done();
    frame_check("post_upd");

    // Asynchronous reset in the middle of the MAC phase.
    wait_c(7, "wait_c7");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mac", int'(bus.oMacEn), 0);
    chk("async_rst_rd",  int'(bus.oCoefRdEn), 0);
    chk("async_rst_addr", int'(bus.oCoefAddr), 0);
    chk("async_rst_busy", int'(bus.oBusy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_sample", int'(bus.oEnSample600k), 1);

`ifdef FIR_SEQ_SKIP_CNT_EN
    rst_n       = 1'b0;
    bus.iEnable = 1'b0;
    @(negedge clk);
    rst_n           = 1'b1;
    bus.iCoefUpdReq = 1'b1;
    @(negedge clk);
    bus.iCoefUpdReq = 1'b0;
    repeat (45) @(negedge clk);
    chk("skip_three", int'(bus.oSkipCnt), 3);
    pulse_done();
`endif

    // Random host traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bus.iCoefUpdDone = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 63) == 0) bus.iEnable = ~bus.iEnable;
      if (!bus.iCoefUpdReq && !bus.oCoefUpdGnt && $urandom_range(0, 79) == 0) bus.iCoefUpdReq = 1'b1;
      else if (bus.iCoefUpdReq && bus.oCoefUpdGnt && $urandom_range(0, 1) == 0) bus.iCoefUpdReq = 1'b0;
    end
    bus.iCoefUpdDone = 1'b0;
    bus.iCoefUpdReq  = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
